// File: rtl/attex_bus_pkg.sv
// attex_bus_pkg
// Shared definitions for the CD-i CPU-side bus controller:
//   - bus_state_e : access sequencer states
//   - counter widths for wait states, ext-ack timeout and IRQ cooldown
//   - field_get() : pulls field idx of a given width out of a packed
//                   parameter vector (base/mask/wait tables)
package attex_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int TMO_CNT_W  = 8;
  localparam int CD_CNT_W   = 8;

  // Packed parameter vectors are widened to this before extraction so a
  // single function serves every table regardless of its real width.
  localparam int PACK_W = 1024;

  function automatic logic [31:0] field_get(input logic [PACK_W-1:0] vec,
                                            input int idx,
                                            input int width);
    logic [PACK_W-1:0] shifted;
    shifted = vec >> (idx * width);
    return shifted[31:0] & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/attex_bus_ctrl_decode.sv
// attex_addr_decode
// Combinational region decoder. Region i hits when
// (addr & mask_i) == (base_i & mask_i); the lowest-index hit wins.
// Ports:
//   addr : CPU word address
//   as   : address strobe, qualifies the chip selects only
//   cs   : one-hot chip selects (all zero when as is low or nothing hits)
//   sel  : index of the winning region (0 when nothing hits)
//   hit  : at least one region matches addr (independent of as)
module attex_addr_decode
  import attex_bus_pkg::*;
#(
  parameter int                         NUM_CS  = 5,
  parameter int                         ADDR_W  = 23,
  parameter int                         SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter logic [NUM_CS*ADDR_W-1:0]   CS_BASE = '0,
  parameter logic [NUM_CS*ADDR_W-1:0]   CS_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              as,
  output logic [NUM_CS-1:0] cs,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  logic [NUM_CS-1:0] hit_v;

  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cmp
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(field_get(PACK_W'(CS_BASE), gi, ADDR_W));
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(field_get(PACK_W'(CS_MASK), gi, ADDR_W));
    assign hit_v[gi] = ((addr & MASK) == (BASE & MASK));
  end

  // Ascending scan; once hit is set, later (higher-index) matches are ignored.
  always_comb begin
    cs  = '0;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (hit_v[i] && !hit) begin
        hit   = 1'b1;
        sel   = SEL_W'(i);
        cs[i] = as;
      end
    end
  end

endmodule

// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl
// CPU-side bus controller: address decode, per-region wait-state or
// external-acknowledge termination, bus error for unmapped / timed-out
// accesses, registered read-data return and a maskable access-interrupt
// cooldown pulse.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   as, uds, lds      : CPU strobes; an access is live while as && (uds || lds)
//   write_strobe      : CPU write qualifier, not needed by the controller
//   addr              : CPU word address
//   cs                : one-hot combinational chip selects
//   slv_rdata         : packed per-region read data
//   ext_ack           : per-region external acknowledge levels
//   data_in           : read data captured on the acknowledging edge
//   bus_ack, bus_err  : one-cycle termination pulses (mutually exclusive)
//   slave_irq         : one-cycle access-interrupt pulse after cooldown
//
// state | meaning
// IDLE  | no access in progress, waiting for strobe
// WAIT  | counting region wait states
// EXT   | waiting for an ext_ack rising edge or the timeout
// DONE  | access terminated, waiting for strobe to drop
module attex_bus_ctrl
  import attex_bus_pkg::*;
#(
  parameter int                        NUM_CS       = 5,
  parameter int                        ADDR_W       = 23,
  parameter int                        DATA_W       = 16,
  parameter logic [NUM_CS*ADDR_W-1:0]  CS_BASE      = '0,
  parameter logic [NUM_CS*ADDR_W-1:0]  CS_MASK      = '0,
  parameter logic [NUM_CS*4-1:0]       CS_WAIT      = '0,
  parameter logic [NUM_CS-1:0]         CS_EXT_ACK   = '0,
  parameter logic [NUM_CS-1:0]         IRQ_MASK     = '0,
  parameter logic [7:0]                IRQ_COOLDOWN = 8'd20,
  parameter logic [7:0]                TIMEOUT      = 8'd255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     as,
  input  logic                     uds,
  input  logic                     lds,
  input  logic                     write_strobe,
  input  logic [ADDR_W-1:0]        addr,
  output logic [NUM_CS-1:0]        cs,
  input  logic [NUM_CS*DATA_W-1:0] slv_rdata,
  input  logic [NUM_CS-1:0]        ext_ack,
  output logic [DATA_W-1:0]        data_in,
  output logic                     bus_ack,
  output logic                     bus_err,
  output logic                     slave_irq
);

  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  // Per-region tables are padded to a power of two so any sel value indexes
  // a defined entry.
  localparam int NSEL  = 1 << SEL_W;

  logic unused_write_strobe;
  assign unused_write_strobe = write_strobe;

  logic             strobe;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_hit;

  assign strobe = as && (uds || lds);

  attex_addr_decode #(
    .NUM_CS  (NUM_CS),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W),
    .CS_BASE (CS_BASE),
    .CS_MASK (CS_MASK)
  ) u_decode (
    .addr (addr),
    .as   (as),
    .cs   (cs),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  logic [WAIT_CNT_W-1:0] wait_tbl  [NSEL];
  logic [DATA_W-1:0]     rdata_tbl [NSEL];
  logic [NSEL-1:0]       ext_en;
  logic [NSEL-1:0]       irq_en;

  for (genvar gi = 0; gi < NSEL; gi++) begin : g_tbl
    if (gi < NUM_CS) begin : g_used
      assign wait_tbl[gi]  = WAIT_CNT_W'(field_get(PACK_W'(CS_WAIT), gi, WAIT_CNT_W));
      assign rdata_tbl[gi] = slv_rdata[gi*DATA_W +: DATA_W];
    end else begin : g_pad
      assign wait_tbl[gi]  = '0;
      assign rdata_tbl[gi] = '0;
    end
  end

  assign ext_en = NSEL'(CS_EXT_ACK);
  assign irq_en = NSEL'(IRQ_MASK);

  bus_state_e            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  hit_q, hit_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [TMO_CNT_W-1:0]  tmo_q, tmo_d;
  logic [CD_CNT_W-1:0]   cd_q, cd_d;
  logic [NUM_CS-1:0]     ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic [NSEL-1:0]       ext_now_x;
  logic [NSEL-1:0]       ext_prev_x;
  logic                  ext_edge;
  logic                  irq_start;

  assign ext_now_x  = NSEL'(ext_ack);
  assign ext_prev_x = NSEL'(ext_ack_q);
  // Only a low-to-high transition on the latched region counts; a level that
  // was already high when the access started never terminates it.
  assign ext_edge   = hit_q && ext_now_x[sel_q] && !ext_prev_x[sel_q];

  assign irq_start  = (state_q == ST_IDLE) && strobe && dec_hit && irq_en[dec_sel];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hit_d     = hit_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ext_ack_d = ext_ack;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          sel_d = dec_sel;
          hit_d = dec_hit;
          if (!dec_hit) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (ext_en[dec_sel]) begin
            state_d = ST_EXT;
            tmo_d   = TIMEOUT;
          end else if (wait_tbl[dec_sel] == '0) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            data_d  = rdata_tbl[dec_sel];
          end else begin
            state_d = ST_WAIT;
            wait_d  = wait_tbl[dec_sel];
          end
        end
      end
      ST_WAIT: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q - WAIT_CNT_W'(1);
          if (wait_q == WAIT_CNT_W'(1)) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            data_d  = rdata_tbl[sel_q];
          end
        end
      end
      ST_EXT: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end else if (ext_edge) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          data_d  = rdata_tbl[sel_q];
        end else begin
          tmo_d = tmo_q - TMO_CNT_W'(1);
          if (tmo_q == TMO_CNT_W'(1)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cooldown: a new armed access reloads, so back-to-back accesses inside the
  // window collapse into one pulse. A reload value of 0 never reaches 1.
  always_comb begin
    cd_d  = cd_q;
    irq_d = (cd_q == CD_CNT_W'(1));
    if (irq_start) begin
      cd_d = IRQ_COOLDOWN;
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      hit_q     <= 1'b0;
      wait_q    <= '0;
      tmo_q     <= '0;
      cd_q      <= '0;
      ext_ack_q <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hit_q     <= hit_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      cd_q      <= cd_d;
      ext_ack_q <= ext_ack_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
    end
  end

  assign data_in   = data_q;
  assign bus_ack   = ack_q;
  assign bus_err   = err_q;
  assign slave_irq = irq_q;

endmodule

// File: tb/tb_attex_bus_ctrl.sv
`timescale 1ns/1ps
module tb_attex_bus_ctrl;

  localparam int NUM_CS = 5;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int COOL   = 20;
  localparam int TMO    = 255;

  localparam logic [NUM_CS*ADDR_W-1:0] P_BASE =
    {23'h300000, 23'h000000, 23'h200000, 23'h100000, 23'h000000};
  localparam logic [NUM_CS*ADDR_W-1:0] P_MASK =
    {23'h7F0000, 23'h7E0000, 23'h7F0000, 23'h7F0000, 23'h7F0000};
  localparam logic [NUM_CS*4-1:0] P_WAIT = {4'd1, 4'd2, 4'd0, 4'd3, 4'd0};

  // Reference region table (index order 0..4)
  localparam int REG_BASE [NUM_CS] = '{'h000000, 'h100000, 'h200000, 'h000000, 'h300000};
  localparam int REG_MASK [NUM_CS] = '{'h7F0000, 'h7F0000, 'h7F0000, 'h7E0000, 'h7F0000};
  localparam int REG_WAIT [NUM_CS] = '{0, 3, 0, 2, 1};
  localparam int REG_EXT  [NUM_CS] = '{0, 0, 1, 0, 0};

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     as = 1'b0, uds = 1'b0, lds = 1'b0, write_strobe = 1'b0;
  logic [ADDR_W-1:0]        addr = '0;
  logic [NUM_CS-1:0]        cs;
  logic [NUM_CS*DATA_W-1:0] slv_rdata = '0;
  logic [NUM_CS-1:0]        ext_ack = '0;
  logic [DATA_W-1:0]        data_in;
  logic                     bus_ack, bus_err, slave_irq;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_data = '0;

  always #5 clk = ~clk;

  attex_bus_ctrl #(
    .NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CS_BASE(P_BASE), .CS_MASK(P_MASK), .CS_WAIT(P_WAIT),
    .CS_EXT_ACK(5'b00100), .IRQ_MASK(5'b00010),
    .IRQ_COOLDOWN(8'd20), .TIMEOUT(8'd255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .as(as), .uds(uds), .lds(lds),
    .write_strobe(write_strobe), .addr(addr), .cs(cs), .slv_rdata(slv_rdata),
    .ext_ack(ext_ack), .data_in(data_in), .bus_ack(bus_ack), .bus_err(bus_err),
    .slave_irq(slave_irq)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_region(input logic [22:0] a);
    for (int i = 0; i < NUM_CS; i++)
      if ((int'(a) & REG_MASK[i]) == (REG_BASE[i] & REG_MASK[i])) return i;
    return -1;
  endfunction

  // Tick n = observation just after the n-th edge counted from the edge
  // that first samples strobe high (tick 1). drop_at/rise_at act after tick n.
  function automatic void ref_outcome(input int r, input int drop_at, input int rise_at,
                                      output int ack_t, output int err_t);
    int done_t;
    bit is_err;
    ack_t = -1;
    err_t = -1;
    if (r < 0) begin
      done_t = 1; is_err = 1'b1;
    end else if (REG_EXT[r] != 0) begin
      if (rise_at >= 1 && rise_at <= TMO) begin done_t = rise_at + 1; is_err = 1'b0; end
      else begin done_t = TMO + 1; is_err = 1'b1; end
    end else begin
      done_t = REG_WAIT[r] + 1; is_err = 1'b0;
    end
    if (drop_at > 0 && drop_at < done_t) return;
    if (is_err) err_t = done_t;
    else ack_t = done_t;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_on(input logic [22:0] a);
    int k;
    k = int'($urandom_range(1, 3));
    addr = a;
    as = 1'b1;
    uds = k[1];
    lds = k[0];
    write_strobe = 1'($urandom);
  endtask

  task automatic strobe_off();
    as = 1'b0; uds = 1'b0; lds = 1'b0;
  endtask

  task automatic randomize_rdata();
    for (int i = 0; i < NUM_CS; i++) slv_rdata[i*DATA_W +: DATA_W] = 16'($urandom);
  endtask

  // rise_at: -1 never, 0 ext_ack[2] already high before the access, n>0 rises after tick n
  task automatic run_access(input logic [22:0] a, input int drop_at, input int rise_at,
                            input int budget, output int ack_t, output int err_t,
                            output int acks, output int errs, output logic [4:0] cs_seen);
    ack_t = -1; err_t = -1; acks = 0; errs = 0;
    if (rise_at == 0) begin
      ext_ack = 5'b00100;
      tick();
    end
    strobe_on(a);
    #1 cs_seen = cs;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (bus_ack) begin acks++; if (ack_t < 0) ack_t = n; end
      if (bus_err) begin errs++; if (err_t < 0) err_t = n; end
      if (n == rise_at) ext_ack = 5'b00100;
      if (n == drop_at) strobe_off();
    end
    strobe_off();
    tick();
    ext_ack = '0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus_ack); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus_err); end
    checks++; if (slave_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", slave_irq); end
    checks++; if (data_in !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", data_in); end
    checks++; if (cs !== 5'b0) begin errors++; $display("FAIL reset_cs got=%b exp=00000", cs); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    int at, et, na, ne;
    logic [4:0] c;
    randomize_rdata();
    slv_rdata[15:0] = 16'h1234;
    run_access(23'h000100, 0, -1, 6, at, et, na, ne, c);
    exp_data = 16'h1234;
    checks++; if (c !== 5'b00001) begin errors++; $display("FAIL zw_cs_overlap got=%b exp=00001", c); end
    checks++; if (at !== 1) begin errors++; $display("FAIL zw_ack_tick got=%0d exp=1", at); end
    checks++; if (na !== 1 || ne !== 0) begin errors++; $display("FAIL zw_pulses acks=%0d errs=%0d exp=1/0", na, ne); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL zw_data got=%h exp=%h", data_in, exp_data); end
  endtask

  task automatic test_wait();
    int at, et, na, ne;
    logic [4:0] c;
    randomize_rdata();
    run_access(23'h100022, 0, -1, 8, at, et, na, ne, c);
    exp_data = slv_rdata[16 +: 16];
    checks++; if (c !== 5'b00010) begin errors++; $display("FAIL w3_cs got=%b exp=00010", c); end
    checks++; if (at !== 4) begin errors++; $display("FAIL w3_ack_tick got=%0d exp=4", at); end
    checks++; if (na !== 1 || ne !== 0) begin errors++; $display("FAIL w3_pulses acks=%0d errs=%0d exp=1/0", na, ne); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL w3_data got=%h exp=%h", data_in, exp_data); end
    // abort after one cycle
    randomize_rdata();
    run_access(23'h100400, 1, -1, 8, at, et, na, ne, c);
    checks++; if (na !== 0 || ne !== 0) begin errors++; $display("FAIL abort_pulses acks=%0d errs=%0d exp=0/0", na, ne); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL abort_data got=%h exp=%h", data_in, exp_data); end
    // region 3 alone (wait 2) right after the abort
    randomize_rdata();
    run_access(23'h01ABCD, 0, -1, 6, at, et, na, ne, c);
    exp_data = slv_rdata[48 +: 16];
    checks++; if (c !== 5'b01000) begin errors++; $display("FAIL r3_cs got=%b exp=01000", c); end
    checks++; if (at !== 3 || na !== 1) begin errors++; $display("FAIL r3_ack tick=%0d acks=%0d exp=3/1", at, na); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL r3_data got=%h exp=%h", data_in, exp_data); end
  endtask

  task automatic test_ext();
    int at, et, na, ne;
    logic [4:0] c;
    randomize_rdata();
    run_access(23'h2000F0, 0, 7, 12, at, et, na, ne, c);
    exp_data = slv_rdata[32 +: 16];
    checks++; if (c !== 5'b00100) begin errors++; $display("FAIL ext_cs got=%b exp=00100", c); end
    checks++; if (at !== 8 || na !== 1 || ne !== 0) begin errors++; $display("FAIL ext_ack tick=%0d acks=%0d errs=%0d exp=8/1/0", at, na, ne); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL ext_data got=%h exp=%h", data_in, exp_data); end
    // level already high: no edge, timeout
    randomize_rdata();
    run_access(23'h200002, 0, 0, TMO + 4, at, et, na, ne, c);
    checks++; if (et !== TMO + 1 || ne !== 1 || na !== 0) begin errors++; $display("FAIL ext_timeout tick=%0d errs=%0d acks=%0d exp=%0d/1/0", et, ne, na, TMO + 1); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL ext_timeout_data got=%h exp=%h", data_in, exp_data); end
  endtask

  task automatic test_unmapped();
    int at, et, na, ne;
    logic [4:0] c;
    randomize_rdata();
    run_access(23'h5A0000, 0, -1, 6, at, et, na, ne, c);
    checks++; if (c !== 5'b00000) begin errors++; $display("FAIL unm_cs got=%b exp=00000", c); end
    checks++; if (et !== 1 || ne !== 1 || na !== 0) begin errors++; $display("FAIL unm_err tick=%0d errs=%0d acks=%0d exp=1/1/0", et, ne, na); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL unm_data got=%h exp=%h", data_in, exp_data); end
  endtask

  task automatic test_irq();
    int pulses, first_t;
    repeat (25) tick();
    // single armed access
    randomize_rdata();
    strobe_on(23'h100010);
    pulses = 0; first_t = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (slave_irq) begin pulses++; if (first_t < 0) first_t = n; end
      if (n == 4) strobe_off();
    end
    exp_data = slv_rdata[16 +: 16];
    checks++; if (pulses !== 1 || first_t !== COOL + 1) begin errors++; $display("FAIL irq_single pulses=%0d tick=%0d exp=1/%0d", pulses, first_t, COOL + 1); end
    // retrigger at cycle 10
    randomize_rdata();
    strobe_on(23'h100020);
    pulses = 0; first_t = -1;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (slave_irq) begin pulses++; if (first_t < 0) first_t = n; end
      if (n == 4 || n == 14) strobe_off();
      if (n == 10) strobe_on(23'h100030);
    end
    exp_data = slv_rdata[16 +: 16];
    checks++; if (pulses !== 1 || first_t !== 10 + COOL + 1) begin errors++; $display("FAIL irq_retrigger pulses=%0d tick=%0d exp=1/%0d", pulses, first_t, 10 + COOL + 1); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL irq_data got=%h exp=%h", data_in, exp_data); end
  endtask

  task automatic test_random();
    logic [6:0] hi_tbl [6];
    int at, et, na, ne, r, drop, rise, budget, eat, eet;
    logic [4:0] c, ecs;
    logic [22:0] a;
    hi_tbl = '{7'h00, 7'h01, 7'h10, 7'h20, 7'h30, 7'h45};
    for (int it = 0; it < 40; it++) begin
      a = {hi_tbl[$urandom_range(0, 5)], 16'($urandom)};
      r = ref_region(a);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      rise = -1;
      if (r == 2) rise = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      budget = (rise == 0) ? TMO + 4 : 20;
      randomize_rdata();
      ref_outcome(r, drop, rise, eat, eet);
      ecs = (r < 0) ? 5'b0 : 5'(1 << r);
      run_access(a, drop, rise, budget, at, et, na, ne, c);
      if (eat > 0) exp_data = slv_rdata[r*16 +: 16];
      checks++; if (c !== ecs) begin errors++; $display("FAIL rnd%0d_cs addr=%h got=%b exp=%b", it, a, c, ecs); end
      checks++; if (at !== eat) begin errors++; $display("FAIL rnd%0d_ack_tick addr=%h got=%0d exp=%0d", it, a, at, eat); end
      checks++; if (et !== eet) begin errors++; $display("FAIL rnd%0d_err_tick addr=%h got=%0d exp=%0d", it, a, et, eet); end
      checks++; if (na !== ((eat > 0) ? 1 : 0) || ne !== ((eet > 0) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_pulses acks=%0d errs=%0d", it, na, ne); end
      checks++; if (data_in !== exp_data) begin errors++; $display("FAIL rnd%0d_data got=%h exp=%h", it, data_in, exp_data); end
    end
  endtask

  task automatic test_reset_mid();
    int at, et, na, ne, pulses;
    logic [4:0] c;
    randomize_rdata();
    strobe_on(23'h100050);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus_ack !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rstmid_ack_err got=%b/%b exp=0/0", bus_ack, bus_err); end
    checks++; if (slave_irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got=%b exp=0", slave_irq); end
    checks++; if (data_in !== 16'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0000", data_in); end
    exp_data = '0;
    strobe_off();
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (bus_ack || bus_err || slave_irq) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d pulses exp=0", pulses); end
    randomize_rdata();
    run_access(23'h30ABCD, 0, -1, 6, at, et, na, ne, c);
    exp_data = slv_rdata[64 +: 16];
    checks++; if (at !== 2 || na !== 1 || ne !== 0) begin errors++; $display("FAIL rstmid_fresh tick=%0d acks=%0d errs=%0d exp=2/1/0", at, na, ne); end
    checks++; if (data_in !== exp_data) begin errors++; $display("FAIL rstmid_fresh_data got=%h exp=%h", data_in, exp_data); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait();
    test_ext();
    test_unmapped();
    test_irq();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
